// File: rtl/ped_request_manager.sv
// ped_request_manager: pedestrian phase front-end for the traffic light FSM.
// Synchronizes and debounces the crosswalk buttons, latches presses as pending
// requests (shown on wait_lamp), drives a single registered ped_req until the
// FSM serves the walk phase, then holds off new requests for a cooldown.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn          raw asynchronous pushbuttons, active-high
//   ped_green    walk indication from the traffic light FSM (already synchronous)
//   ped_req      registered request to the FSM, high only in REQUEST
//   wait_lamp    per-button request-pending lamps
//   served_pulse one-cycle pulse when a walk phase completes
//   serve_count  completed walk phases, saturating at 255
module ped_request_manager #(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn,
  input  logic                   ped_green,
  output logic                   ped_req,
  output logic [NUM_BUTTONS-1:0] wait_lamp,
  output logic                   served_pulse,
  output logic [7:0]             serve_count
);

  localparam int unsigned DB_W = 4;
  localparam int unsigned CD_W = 8;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LAST =
    CD_W'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t                 state;
  logic [NUM_BUTTONS-1:0] s1;
  logic [NUM_BUTTONS-1:0] s2;
  logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] recog;
  logic [NUM_BUTTONS-1:0] pending;
  logic [CD_W-1:0]        cd_cnt;

  assign wait_lamp = pending;

  // Two-flop synchronizer and saturating per-button debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (!s2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DB_MAX)
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  // A press is recognized only on the DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES step,
  // so a held button cannot re-trigger until s2 has dropped.
  always_comb begin
    recog = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      recog[i] = s2[i] && (db_cnt[i] == DB_LAST);
  end

  // Request/serve/cooldown state machine with registered outputs.
  // Entering SERVING always clears pending, overriding a same-cycle recognition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      ped_req      <= 1'b0;
      served_pulse <= 1'b0;
      serve_count  <= '0;
      cd_cnt       <= '0;
    end else begin
      served_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ped_green) begin
            state   <= SERVING;
            pending <= '0;
            ped_req <= 1'b0;
          end else begin
            pending <= pending | recog;
            if (|pending) begin
              state   <= REQUEST;
              ped_req <= 1'b1;
            end
          end
        end
        REQUEST: begin
          if (ped_green) begin
            state   <= SERVING;
            pending <= '0;
            ped_req <= 1'b0;
          end else begin
            pending <= pending | recog;
          end
        end
        SERVING: begin
          if (!ped_green) begin
            served_pulse <= 1'b1;
            if (serve_count != 8'hFF) serve_count <= serve_count + 8'd1;
            if (COOLDOWN_CYCLES == 0) begin
              if (|pending) begin
                state   <= REQUEST;
                ped_req <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              state  <= COOLDOWN;
              cd_cnt <= '0;
            end
          end
        end
        COOLDOWN: begin
          if (ped_green) begin
            state   <= SERVING;
            pending <= '0;
          end else begin
            pending <= pending | recog;
            if (cd_cnt == CD_LAST) begin
              if (|pending) begin
                state   <= REQUEST;
                ped_req <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              cd_cnt <= cd_cnt + CD_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
          ped_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
